// File: rtl/rv32i_types_pkg.sv
// rv32i_types_pkg: shared RV32I load/store size type and lane helpers.
package rv32i_types_pkg;
  typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} load_t;
  function automatic logic [3:0] rev4(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction
endpackage

// File: rtl/dmem_extender.sv
// dmem_extender: picks the lowest enabled lane of a bus word and sign/zero-extends it.
module dmem_extender
  import rv32i_types_pkg::*;
(
  input  logic [31:0] word,
  input  logic [3:0]  lanes,
  input  load_t       load_type,
  output logic [31:0] data
);
  logic [1:0] lane;
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    lane = lanes[0] ? 2'd0 : lanes[1] ? 2'd1 : lanes[2] ? 2'd2 : lanes[3] ? 2'd3 : 2'd0;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    data = load_type == LB  ? {{24{b[7]}}, b} :
           load_type == LBU ? {24'd0, b} :
           load_type == LH  ? {{16{h[15]}}, h} :
           load_type == LHU ? {16'd0, h} : word;
  end
endmodule

// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl: turns one memory-stage load/store into a generic bus access with
// misalignment faults, flush squashing and load-result extension.
module lsu_bus_ctrl
  import rv32i_types_pkg::*;
#(
  parameter string BUS_ENDIANNESS = "little"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] addr,
  input  logic [3:0]  byte_en,
  input  load_t       load_type,
  input  logic [31:0] store_data,
  input  logic [4:0]  reg_rd,
  input  logic        mal_addr,
  input  logic        flush,
  output logic [31:0] bus_addr,
  output logic        bus_ren,
  output logic        bus_wen,
  output logic [3:0]  bus_byte_en,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        st_done,
  output logic        fault_valid,
  output logic        fault_is_load,
  output logic [31:0] fault_addr,
  output logic        lsu_busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam bit LITTLE = (BUS_ENDIANNESS == "little");
  state_t state, next;
  logic [31:0] addr_q, wdata_q, rdata_q, wb_data_q, ext;
  logic [3:0] lanes_q;
  load_t type_q;
  logic [4:0] rd_q, wb_rd_q;
  logic load_q, squash_q, accept, go, pulse;
  assign req_ready = state == IDLE && !flush && !RST;
  assign accept = req_valid && req_ready && (dren || dwen);
  assign go = accept && !mal_addr;
  assign lsu_busy = state != IDLE;
  assign bus_addr = addr_q;
  assign bus_byte_en = lanes_q;
  assign bus_wdata = wdata_q;
  assign wb_data = wb_valid ? ext : wb_data_q;
  assign wb_rd = wb_valid ? rd_q : wb_rd_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state == IDLE && go ? ACCESS :
           state == ACCESS && !bus_busy ? RESP :
           state == RESP ? IDLE : state;
    bus_ren = state == ACCESS && load_q;
    bus_wen = state == ACCESS && !load_q;
    pulse = state == RESP && !squash_q && !flush;
    wb_valid = pulse && load_q;
    st_done = pulse && !load_q;
  end
  // A flush seen anywhere in ACCESS sticks until RESP so the late response is dropped.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= '0;
      lanes_q <= '0;
      type_q <= LB;
      rd_q <= '0;
      load_q <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      squash_q <= 1'b0;
      fault_valid <= 1'b0;
      fault_addr <= '0;
      fault_is_load <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q <= '0;
    end else begin
      if (go) begin
        addr_q <= addr;
        lanes_q <= !dren && LITTLE ? rev4(byte_en) : byte_en;
        type_q <= load_type;
        rd_q <= reg_rd;
        load_q <= dren;
        wdata_q <= load_type inside {LB, LBU} ? {4{store_data[7:0]}} :
                   load_type inside {LH, LHU} ? {2{store_data[15:0]}} : store_data;
      end
      if (state == ACCESS && !bus_busy) rdata_q <= bus_rdata;
      squash_q <= state == ACCESS && (squash_q || flush);
      fault_valid <= accept && mal_addr;
      if (accept && mal_addr) begin
        fault_addr <= addr;
        fault_is_load <= dren;
      end
      if (wb_valid) begin
        wb_data_q <= ext;
        wb_rd_q <= rd_q;
      end
    end
  end
  dmem_extender u_ext (
    .word(rdata_q),
    .lanes(lanes_q),
    .load_type(type_q),
    .data(ext)
  );
endmodule
